d_lsu_v1: RTL and testbench

Load/store unit sitting directly upstream of the data SRAM wrapper (`d_cache_v1`). It accepts one core memory request at a time over a valid/ready handshake and converts it into SRAM word accesses. For stores, it generates the word address, legal write strobe and lane-packed store data. For loads, it aligns, sign- or zero-extends, and registers the fetched data back to the core. Misaligned accesses are either split into byte accesses or rejected, selected at compile time.

---
 rtl/d_lsu_v1.sv | 258 +++++++++++++++++++++++++
 tb/tb_d_lsu_v1.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_lsu_v1.sv
// d_lsu_v1: load/store unit in front of the data SRAM wrapper.
// Takes one core request at a time. It drives registered SRAM word accesses,
// then aligns and extends load data into a one-cycle response.
// Compile option: define D_LSU_MISALIGN_EN to split misaligned half/word
// accesses into ascending byte accesses. Without it, such accesses are
// rejected with resp_err.
module d_lsu_v1 #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              data_enable,
  output logic              data_read,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_store,
  input  logic [31:0]       ram_fetch
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  localparam logic [ADDR_W+1:0] BYTE_STEP = 1;

  state_t state, state_nx;

  // latched request
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic              split_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic [ADDR_W+1:0] baddr_q;
  logic [31:0]       result_q;

  // request decode
  logic       accept;
  logic       bad_size;
  logic       misaligned;
  logic       req_err;
  logic       req_split;
  logic [1:0] req_last;

  // fields of the access about to be launched
  logic              a_we;
  logic [1:0]        a_size;
  logic              a_split;
  logic [1:0]        a_k;
  logic [ADDR_W+1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [31:0]       a_lane;
  logic [3:0]        a_strb;
  logic [31:0]       a_store;

  // load merge path
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  // upper byte-address bits do not reach the SRAM
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && (state == IDLE);

  // classify the incoming request: illegal size, misalignment, access count
  always_comb begin
    bad_size   = (req_size == 2'b11);
    misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef D_LSU_MISALIGN_EN
    req_err   = bad_size;
    req_split = misaligned && !bad_size;
    req_last  = !req_split ? 2'd0 : (req_size == 2'b01) ? 2'd1 : 2'd3;
`else
    req_err   = bad_size || misaligned;
    req_split = 1'b0;
    req_last  = 2'd0;
`endif
  end

  // build address/strobe/data for the next SRAM access
  always_comb begin
    if (state == IDLE) begin
      a_we    = req_we;
      a_size  = req_size;
      a_split = req_split;
      a_k     = 2'd0;
      a_addr  = req_addr[ADDR_W+1:0];
      a_wdata = req_wdata;
    end else begin
      a_we    = we_q;
      a_size  = size_q;
      a_split = split_q;
      a_k     = idx_q + 2'd1;
      a_addr  = baddr_q + BYTE_STEP;
      a_wdata = wdata_q;
    end
    a_lane  = a_wdata >> {a_k, 3'b000};
    a_strb  = 4'b0000;
    a_store = '0;
    if (a_we) begin
      if (a_split) begin
        a_strb  = 4'b0001 << a_addr[1:0];
        a_store = {24'h0, a_lane[7:0]};
      end else begin
        case (a_size)
          2'b00: begin
            a_strb  = 4'b0001 << a_addr[1:0];
            a_store = {24'h0, a_wdata[7:0]};
          end
          2'b01: begin
            a_strb  = a_addr[1] ? 4'b1100 : 4'b0011;
            a_store = {16'h0, a_wdata[15:0]};
          end
          default: begin
            a_strb  = 4'b1111;
            a_store = a_wdata;
          end
        endcase
      end
    end
  end

  // align fetched word and merge it into the result register
  always_comb begin
    shifted   = ram_fetch >> {baddr_q[1:0], 3'b000};
    lane_mask = 32'h0000_00FF << {idx_q, 3'b000};
    if (split_q) begin
      merged = (result_q & ~lane_mask) |
               ({24'h0, shifted[7:0]} << {idx_q, 3'b000});
    end else begin
      merged = shifted;
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] v,
                                         input logic [1:0] size,
                                         input logic uns);
    logic [31:0] r;
    case (size)
      2'b00:   r = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   r = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state; errors pass through ACCESS without enabling the SRAM so the
  // response lands one cycle after acceptance
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  state_nx = err_q ? RESP : CAPTURE;
      CAPTURE: state_nx = (idx_q == last_q) ? RESP : ACCESS;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // request latch, SRAM output registers and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      split_q     <= 1'b0;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      baddr_q     <= '0;
      result_q    <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      data_enable <= 1'b0;
      data_read   <= 1'b1;
      mem_wstrb   <= 4'b0000;
      ram_address <= '0;
      ram_store   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            split_q  <= req_split;
            idx_q    <= 2'd0;
            last_q   <= req_last;
            baddr_q  <= a_addr;
            result_q <= '0;
            if (!req_err) begin
              data_enable <= 1'b1;
              data_read   <= ~req_we;
              ram_address <= a_addr[ADDR_W+1:2];
              mem_wstrb   <= a_strb;
              ram_store   <= a_store;
            end
          end
        end
        ACCESS: begin
          data_enable <= 1'b0;
          data_read   <= 1'b1;
          mem_wstrb   <= 4'b0000;
          if (err_q) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        CAPTURE: begin
          result_q <= merged;
          if (idx_q != last_q) begin
            idx_q       <= a_k;
            baddr_q     <= a_addr;
            data_enable <= 1'b1;
            data_read   <= ~we_q;
            ram_address <= a_addr[ADDR_W+1:2];
            mem_wstrb   <= a_strb;
            ram_store   <= a_store;
          end else begin
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? 32'h0 : extend(merged, size_q, uns_q);
          end
        end
        RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_lsu_v1.sv
// Bench for d_lsu_v1 with a byte-strobed SRAM model and scoreboard queues.
// Honours D_LSU_MISALIGN_EN to select expected split or error behaviour.
module tb_d_lsu_v1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        data_enable, data_read;
  logic [3:0]  mem_wstrb;
  logic [11:0] ram_address;
  logic [31:0] ram_store, ram_fetch;

  d_lsu_v1 #(.ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .data_enable(data_enable), .data_read(data_read),
    .mem_wstrb(mem_wstrb), .ram_address(ram_address), .ram_store(ram_store),
    .ram_fetch(ram_fetch)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM model: right-justified store data placed at the lowest strobed lane
  logic [31:0] mem [0:4095];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h4433_2211;
      mem[1] <= 32'h8877_6655;
    end else if (data_enable) begin
      if (data_read) begin
        ram_fetch <= mem[ram_address];
      end else begin
        logic [31:0] wd;
        logic [31:0] cur;
        int low;
        low = mem_wstrb[0] ? 0 : mem_wstrb[1] ? 1 : mem_wstrb[2] ? 2 : 3;
        wd  = ram_store << (8 * low);
        cur = mem[ram_address];
        for (int j = 0; j < 4; j++)
          if (mem_wstrb[j]) cur[8*j +: 8] = wd[8*j +: 8];
        mem[ram_address] <= cur;
      end
    end
  end

  typedef struct {
    int unsigned cyc;
    logic        we;
    logic [11:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] mask;
  } acc_t;
  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  acc_t accq[$];
  rsp_t rspq[$];

  // monitor: compare every SRAM access and every response against the queues
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (data_enable) begin
        if (accq.size() == 0) begin
          chk("unexpected_access", {20'h0, ram_address}, 32'hFFFF_FFFF);
        end else begin
          acc_t a;
          a = accq.pop_front();
          chk("acc_cycle", cyc, a.cyc);
          chk("acc_read", {31'h0, data_read}, {31'h0, ~a.we});
          chk("acc_addr", {20'h0, ram_address}, {20'h0, a.addr});
          chk("acc_strb", {28'h0, mem_wstrb}, {28'h0, a.strb});
          chk("acc_store", ram_store & a.mask, a.data & a.mask);
        end
      end
      if (resp_valid) begin
        if (rspq.size() == 0) begin
          chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
        end else begin
          rsp_t r;
          r = rspq.pop_front();
          chk("resp_cycle", cyc, r.cyc);
          chk("resp_err", {31'h0, resp_err}, {31'h0, r.err});
          chk("resp_rdata", resp_rdata, r.rdata);
        end
      end
    end
  end

  task automatic push_acc(input int unsigned c, input logic we, input logic [11:0] addr,
                          input logic [3:0] strb, input logic [31:0] data, input logic [31:0] mask);
    acc_t a;
    a.cyc = c; a.we = we; a.addr = addr; a.strb = strb; a.data = data; a.mask = mask;
    accq.push_back(a);
  endtask

  task automatic push_rsp(input int unsigned c, input logic err, input logic [31:0] rdata);
    rsp_t r;
    r.cyc = c; r.err = err; r.rdata = rdata;
    rspq.push_back(r);
  endtask

  // drive one request; e0 is the count of the accepting edge
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int unsigned e0);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    e0 = cyc;
    req_valid = 1'b0;
    // junk on ignored inputs
    req_we = ~we; req_size = ~size; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((accq.size() != 0 || rspq.size() != 0 || !req_ready) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (accq.size() != 0 || rspq.size() != 0)
      chk("drain_timeout", accq.size() + rspq.size(), 32'h0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready",   {31'h0, req_ready},   32'h1);
    chk("rst_resp_valid",  {31'h0, resp_valid},  32'h0);
    chk("rst_resp_rdata",  resp_rdata,           32'h0);
    chk("rst_resp_err",    {31'h0, resp_err},    32'h0);
    chk("rst_data_enable", {31'h0, data_enable}, 32'h0);
    chk("rst_data_read",   {31'h0, data_read},   32'h1);
    chk("rst_mem_wstrb",   {28'h0, mem_wstrb},   32'h0);
    chk("rst_ram_address", {20'h0, ram_address}, 32'h0);
    chk("rst_ram_store",   ram_store,            32'h0);
  endtask

  // aligned single-access request with hand-computed outcome
  task automatic aligned(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] sdata,
                         input logic [31:0] smask, input logic [31:0] rdata);
    int unsigned e0;
    issue(we, size, uns, addr, wdata, e0);
    push_acc(e0, we, addr[13:2], strb, sdata, smask);
    push_rsp(e0 + 2, 1'b0, rdata);
    drain();
  endtask

  task automatic error_req(input logic we, input logic [1:0] size,
                           input logic [31:0] addr);
    int unsigned e0;
    issue(we, size, 1'b0, addr, 32'h1357_9BDF, e0);
    push_rsp(e0 + 1, 1'b1, 32'h0);
    drain();
  endtask

  initial begin
    int unsigned e0;
    int guard;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // word store then load
    aligned(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0);
    aligned(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h0,         32'h0,         32'hDEAD_BEEF);
    // byte store into lane 3, signed/unsigned byte and half loads
    aligned(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h1234_5680, 4'b1000, 32'h0000_0080, 32'h0000_00FF, 32'h0);
    aligned(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         4'b0000, 32'h0,         32'h0,         32'hFFFF_FF80);
    aligned(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         4'b0000, 32'h0,         32'h0,         32'h0000_0080);
    aligned(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         4'b0000, 32'h0,         32'h0,         32'hFFFF_80AD);
    aligned(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         4'b0000, 32'h0,         32'h0,         32'h0000_80AD);

    // illegal size
    error_req(1'b1, 2'b11, 32'h0000_0020);
    error_req(1'b0, 2'b11, 32'h0000_0024);

    // misaligned word load at 0x1
`ifdef D_LSU_MISALIGN_EN
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, e0);
    push_acc(e0,     1'b0, 12'h000, 4'b0000, 32'h0, 32'h0);
    push_acc(e0 + 2, 1'b0, 12'h000, 4'b0000, 32'h0, 32'h0);
    push_acc(e0 + 4, 1'b0, 12'h000, 4'b0000, 32'h0, 32'h0);
    push_acc(e0 + 6, 1'b0, 12'h001, 4'b0000, 32'h0, 32'h0);
    push_rsp(e0 + 8, 1'b0, 32'h5544_3322);
    drain();
`else
    error_req(1'b0, 2'b10, 32'h0000_0001);
`endif

    // aligned half store at upper half, then half loads
    aligned(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'hFFFF_1234, 4'b1100, 32'h0000_1234, 32'h0000_FFFF, 32'h0);
    aligned(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,         4'b0000, 32'h0,         32'h0,         32'h0000_1234);
    aligned(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0,         32'h0,         32'h0000_2211);

    // misaligned half store across the word-address wrap
`ifdef D_LSU_MISALIGN_EN
    issue(1'b1, 2'b01, 1'b0, 32'h0000_3FFF, 32'h0000_A5B6, e0);
    push_acc(e0,     1'b1, 12'hFFF, 4'b1000, 32'h0000_00B6, 32'h0000_00FF);
    push_acc(e0 + 2, 1'b1, 12'h000, 4'b0001, 32'h0000_00A5, 32'h0000_00FF);
    push_rsp(e0 + 4, 1'b0, 32'h0);
    drain();
    aligned(1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0000_00A5);
    aligned(1'b0, 2'b10, 1'b0, 32'h0000_3FFC, 32'h0, 4'b0000, 32'h0, 32'h0, 32'hB600_0000);
`else
    error_req(1'b1, 2'b01, 32'h0000_3FFF);
    aligned(1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0000_0011);
    aligned(1'b0, 2'b10, 1'b0, 32'h0000_3FFC, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0000_0000);
`endif

    // reset during CAPTURE: no response, outputs back to reset values
`ifdef D_LSU_MISALIGN_EN
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, e0);
    push_acc(e0,     1'b0, 12'h000, 4'b0000, 32'h0, 32'h0);
    push_acc(e0 + 2, 1'b0, 12'h000, 4'b0000, 32'h0, 32'h0);
    e0 = e0 + 3;
`else
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, e0);
    push_acc(e0, 1'b0, 12'h004, 4'b0000, 32'h0, 32'h0);
    e0 = e0 + 1;
`endif
    guard = 0;
    @(negedge clk);
    while (cyc != e0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("capture_cycle_reached", cyc, e0);
    chk("pending_accesses_seen", accq.size(), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    accq.delete();
    rspq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_no_resp", {31'h0, resp_valid}, 32'h0);

    // normal service after reset
    aligned(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h80AD_BEEF);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
